// File: rtl/s4ga_pkg.sv
// Shared sizing helpers and FSM encoding for the s4ga LUT fabric and its config streamer.
package s4ga_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} state_t;

  function automatic int n_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int idx_segs(input int n, input int si_w);
    return (n_w(n) + si_w - 1) / si_w;
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return ((1 << k) + si_w - 1) / si_w;
  endfunction

  function automatic int lut_segs(input int n, input int k, input int si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction

  function automatic int cfg_depth(input int n, input int k, input int si_w);
    return n * lut_segs(n, k, si_w);
  endfunction

endpackage

// File: rtl/s4ga_cfg_ram.sv
// Config RAM: one write port, one synchronous read port with 1-cycle latency, no reset.
module s4ga_cfg_ram #(
  parameter int DEPTH = 960,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Loads the s4ga config bitstream once over valid/ready, then replays it one segment per
// clock to the core after holding the core in reset long enough for its serial reset.
module s4ga_cfg_streamer
  import s4ga_pkg::*;
#(
  parameter int N          = 80,
  parameter int K          = 4,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [SI_W-1:0] wr_data,
  input  logic            run_en,
  output logic            loaded,
  output logic [SI_W-1:0] si_out,
  output logic            core_rst,
  output logic            frame_start
);

  localparam int DEPTH = cfg_depth(N, K, SI_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RST_CYCLES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RST_CYCLES - 1);

  if (RST_CYCLES <= N) begin : g_bad_rst_cycles
    $error("s4ga_cfg_streamer: RST_CYCLES must exceed N");
  end

  // Write handshake: a segment transfers on a rising clk edge where wr_valid && wr_ready;
  // wr_ready depends only on state, and wr_data must be stable while wr_valid is high.

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] rst_cnt;
  logic             frame_q;
  logic             wr_en;
  logic [SI_W-1:0]  rd_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (load_start)            state_nxt = LOAD;
        else if (run_en && loaded) state_nxt = INIT;
      end
      LOAD: begin
        if (!load_start && wr_valid && wr_ptr == LAST_PTR) state_nxt = IDLE;
      end
      INIT: begin
        if (load_start)               state_nxt = LOAD;
        else if (!run_en)             state_nxt = IDLE;
        else if (rst_cnt == LAST_CNT) state_nxt = RUN;
      end
      RUN: begin
        if (load_start)   state_nxt = LOAD;
        else if (!run_en) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ready    = 1'b0;
    core_rst    = 1'b1;
    si_out      = '0;
    frame_start = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: wr_ready = 1'b1;
      INIT: ;
      RUN: begin
        core_rst    = 1'b0;
        si_out      = rd_data;
        frame_start = frame_q;
      end
    endcase
  end

  // A restart request discards the write offered in the same cycle.
  assign wr_en = wr_ready && wr_valid && !load_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rst_cnt <= '0;
      loaded  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (load_start) begin
        wr_ptr <= '0;
        loaded <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (wr_ptr == LAST_PTR) loaded <= 1'b1;
      end

      rst_cnt <= (state == INIT) ? rst_cnt + 1'b1 : '0;

      // rd_ptr is the address being read this cycle, one segment ahead of si_out;
      // it sits at 0 outside RUN so the final INIT cycle prefetches segment 0.
      if (state_nxt == RUN) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      else                  rd_ptr <= '0;

      frame_q <= (rd_ptr == '0);
    end
  end

  s4ga_cfg_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SI_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule
